// File: rtl/vga_pkg.sv
// Shared constants for the raster timing generator: default counter width,
// standard display mode parameter sets and total-length helpers.
package vga_pkg;

    localparam int CW_DEFAULT = 12;

    // 640x480 @ 60 Hz, negative sync polarity
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_HS_POL   = 1'b0;
    localparam bit VGA640_VS_POL   = 1'b0;

    // 800x600 @ 60 Hz, positive sync polarity
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_HS_POL   = 1'b1;
    localparam bit SVGA800_VS_POL   = 1'b1;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around counter for one raster axis; wrap pulses on the enabled
// cycle where the count rolls from TOTAL-1 back to zero.
module vga_axis_counter #(
    parameter int CW    = 12,
    parameter int TOTAL = 800
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] TERM = CW'(TOTAL - 1);

    logic at_term;

    assign at_term = (count == TERM);
    assign wrap    = en && at_term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= at_term ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: registered syncs, data enable,
// pixel coordinates and line/frame start strobes, advanced by pix_en.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CW       = CW_DEFAULT,
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit HS_POL   = VGA640_HS_POL,
    parameter bit VS_POL   = VGA640_VS_POL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x_ptr,
    output logic [CW-1:0] y_ptr,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_START_C = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_START_C = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END_C   = CW'(V_ACTIVE + V_FP + V_SYNC);

    if (CW < 1 || CW > 30) begin : g_bad_cw
        $error("vga_timing_gen: CW must be in 1..30");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_field
        $error("vga_timing_gen: every porch/sync/active field must be at least 1");
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;

    // The vertical axis only advances on the horizontal roll-over.
    vga_axis_counter #(.CW(CW), .TOTAL(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.CW(CW), .TOTAL(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    logic h_act;
    logic v_act;
    logic in_hs;
    logic in_vs;
    logic de_next;
    logic frame_wrap;

    assign h_act      = (h_cnt < H_ACT_C);
    assign v_act      = (v_cnt < V_ACT_C);
    assign in_hs      = (h_cnt >= HS_START_C) && (h_cnt < HS_END_C);
    assign in_vs      = (v_cnt >= VS_START_C) && (v_cnt < VS_END_C);
    assign de_next    = h_act && v_act;
    assign frame_wrap = v_wrap;

    // Outputs reflect the pixel under the counters before they advance;
    // strobes drop on idle cycles so each lasts exactly one clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x_ptr       <= '0;
            y_ptr       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hsync       <= in_hs ? HS_POL : ~HS_POL;
            vsync       <= in_vs ? VS_POL : ~VS_POL;
            de          <= de_next;
            x_ptr       <= de_next ? h_cnt : '0;
            y_ptr       <= de_next ? v_cnt : '0;
            line_start  <= (h_cnt == '0) && v_act;
            frame_start <= (h_cnt == '0) && (v_cnt == '0) && !frame_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three generator instances (640x480, a tiny mode, 800x600)
// compared against a pixel-index reference model with randomized pixel enables.
module tb_vga_timing_gen;

    localparam int CW = 12;
    localparam int OW = 2 * CW + 5;

    // Tiny mode used for full-frame, enable-ratio and reset scenarios
    localparam int B_HA = 10, B_HF = 2, B_HS = 3, B_HB = 4;
    localparam int B_VA = 6,  B_VF = 1, B_VS = 2, B_VB = 2;
    localparam int B_FRAME = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          rst_n_a, pix_en_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a;
    logic [CW-1:0] x_ptr_a, y_ptr_a;
    logic          rst_n_b, pix_en_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
    logic [CW-1:0] x_ptr_b, y_ptr_b;
    logic          rst_n_c, pix_en_c, hsync_c, vsync_c, de_c, line_start_c, frame_start_c;
    logic [CW-1:0] x_ptr_c, y_ptr_c;

    logic [OW-1:0] out_a, out_b, out_c;
    assign out_a = {hsync_a, vsync_a, de_a, x_ptr_a, y_ptr_a, line_start_a, frame_start_a};
    assign out_b = {hsync_b, vsync_b, de_b, x_ptr_b, y_ptr_b, line_start_b, frame_start_b};
    assign out_c = {hsync_c, vsync_c, de_c, x_ptr_c, y_ptr_c, line_start_c, frame_start_c};

    vga_timing_gen u_dut_a (
        .clk (clk), .rst_n (rst_n_a), .pix_en (pix_en_a),
        .hsync (hsync_a), .vsync (vsync_a), .de (de_a),
        .x_ptr (x_ptr_a), .y_ptr (y_ptr_a),
        .line_start (line_start_a), .frame_start (frame_start_a)
    );

    vga_timing_gen #(
        .CW (CW), .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
        .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
        .HS_POL (1'b0), .VS_POL (1'b1)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n_b), .pix_en (pix_en_b),
        .hsync (hsync_b), .vsync (vsync_b), .de (de_b),
        .x_ptr (x_ptr_b), .y_ptr (y_ptr_b),
        .line_start (line_start_b), .frame_start (frame_start_b)
    );

    vga_timing_gen #(
        .CW (CW), .H_ACTIVE (800), .H_FP (40), .H_SYNC (128), .H_BP (88),
        .V_ACTIVE (600), .V_FP (1), .V_SYNC (4), .V_BP (23),
        .HS_POL (1'b1), .VS_POL (1'b1)
    ) u_dut_c (
        .clk (clk), .rst_n (rst_n_c), .pix_en (pix_en_c),
        .hsync (hsync_c), .vsync (vsync_c), .de (de_c),
        .x_ptr (x_ptr_c), .y_ptr (y_ptr_c),
        .line_start (line_start_c), .frame_start (frame_start_c)
    );

    // Expected outputs for the p-th enabled pixel since reset, from raster position.
    function automatic logic [OW-1:0] ref_pixel(input int p,
            input int ha, input int hf, input int hs, input int hb,
            input int va, input int vf, input int vs, input int vb,
            input bit hp, input bit vp);
        int ht, vt, h, v;
        logic de_r, hs_r, vs_r, ls_r, fs_r;
        logic [CW-1:0] x_r, y_r;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        h    = p % ht;
        v    = (p / ht) % vt;
        de_r = (h < ha) && (v < va);
        hs_r = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
        vs_r = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
        x_r  = de_r ? CW'(h) : '0;
        y_r  = de_r ? CW'(v) : '0;
        ls_r = (h == 0) && (v < va);
        fs_r = (h == 0) && (v == 0);
        return {hs_r, vs_r, de_r, x_r, y_r, ls_r, fs_r};
    endfunction

    function automatic logic [OW-1:0] reset_vec(input bit hp, input bit vp);
        return {!hp, !vp, 1'b0, {CW{1'b0}}, {CW{1'b0}}, 2'b00};
    endfunction

    task automatic test_reset();
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_en_a = 1'($urandom_range(0, 1));
            pix_en_b = 1'($urandom_range(0, 1));
            pix_en_c = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        total++;
        if (out_a !== reset_vec(1'b0, 1'b0)) begin
            bad++; $display("[TB] FAIL reset_a got=%h want=%h", out_a, reset_vec(1'b0, 1'b0));
        end
        total++;
        if (out_b !== reset_vec(1'b0, 1'b1)) begin
            bad++; $display("[TB] FAIL reset_b got=%h want=%h", out_b, reset_vec(1'b0, 1'b1));
        end
        total++;
        if (out_c !== reset_vec(1'b1, 1'b1)) begin
            bad++; $display("[TB] FAIL reset_c got=%h want=%h", out_c, reset_vec(1'b1, 1'b1));
        end
    endtask

    task automatic test_default_lines();
        int p, de_run, hs_len, de_fall_c, n_de_fall, n_hs_rise;
        logic prev_de, prev_hs;
        logic [OW-1:0] exp_v;
        p = 0; de_run = 0; hs_len = 0; de_fall_c = -1; n_de_fall = 0; n_hs_rise = 0;
        prev_de = 1'b0; prev_hs = 1'b1;
        rst_n_a = 1'b1; pix_en_a = 1'b1;
        for (int c = 0; c < 3 * 800; c++) begin
            @(posedge clk); #1;
            exp_v = ref_pixel(p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
            p++;
            total++;
            if (out_a !== exp_v) begin
                bad++; $display("[TB] FAIL default_pixel p=%0d got=%h want=%h", p - 1, out_a, exp_v);
            end
            if (de_a) de_run++;
            if (prev_de && !de_a) begin
                total++;
                if (de_run != 640) begin
                    bad++; $display("[TB] FAIL default_de_run got=%0d want=640", de_run);
                end
                de_run = 0; de_fall_c = c; n_de_fall++;
            end
            if (!hsync_a) hs_len++;
            if (prev_hs && !hsync_a) begin
                total++;
                if (c - de_fall_c != 16) begin
                    bad++; $display("[TB] FAIL default_de_to_hsync got=%0d want=16", c - de_fall_c);
                end
            end
            if (!prev_hs && hsync_a) begin
                total++;
                if (hs_len != 96) begin
                    bad++; $display("[TB] FAIL default_hsync_width got=%0d want=96", hs_len);
                end
                hs_len = 0; n_hs_rise++;
            end
            prev_de = de_a; prev_hs = hsync_a;
        end
        total++;
        if (n_de_fall != 3 || n_hs_rise != 3) begin
            bad++; $display("[TB] FAIL default_line_events got=%0d/%0d want=3/3", n_de_fall, n_hs_rise);
        end
    endtask

    task automatic test_wide_mode();
        int p, ls_c, hs_len, n_rise, max_x;
        logic prev_hs;
        logic [OW-1:0] exp_v;
        p = 0; ls_c = -1; hs_len = 0; n_rise = 0; max_x = 0; prev_hs = 1'b0;
        rst_n_c = 1'b1; pix_en_c = 1'b1;
        for (int c = 0; c < 2 * 1056; c++) begin
            @(posedge clk); #1;
            exp_v = ref_pixel(p, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
            p++;
            total++;
            if (out_c !== exp_v) begin
                bad++; $display("[TB] FAIL wide_pixel p=%0d got=%h want=%h", p - 1, out_c, exp_v);
            end
            if (line_start_c) ls_c = c;
            if (de_c && int'(x_ptr_c) > max_x) max_x = int'(x_ptr_c);
            if (hsync_c) hs_len++;
            if (!prev_hs && hsync_c) begin
                total++;
                if (c - ls_c != 840) begin
                    bad++; $display("[TB] FAIL wide_hsync_offset got=%0d want=840", c - ls_c);
                end
                n_rise++;
            end
            if (prev_hs && !hsync_c) begin
                total++;
                if (hs_len != 128) begin
                    bad++; $display("[TB] FAIL wide_hsync_width got=%0d want=128", hs_len);
                end
                hs_len = 0;
            end
            prev_hs = hsync_c;
        end
        total++;
        if (max_x != 799 || n_rise != 2) begin
            bad++; $display("[TB] FAIL wide_max_x got=%0d/%0d want=799/2", max_x, n_rise);
        end
    endtask

    task automatic test_random_enable();
        int p, ticks, last_fs, n_period, viol;
        logic en;
        logic [OW-1:0] exp_v, held;
        p = 0; ticks = 0; last_fs = -1; n_period = 0; viol = 0;
        held = reset_vec(1'b0, 1'b1);
        rst_n_b = 1'b1;
        for (int c = 0; c < 1300; c++) begin
            en = 1'($urandom_range(0, 1));
            pix_en_b = en;
            @(posedge clk); #1;
            if (en) begin
                exp_v = ref_pixel(p, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b0, 1'b1);
                p++; ticks++;
            end else begin
                exp_v = {held[OW-1:2], 2'b00};
            end
            held = exp_v;
            total++;
            if (out_b !== exp_v) begin
                bad++; $display("[TB] FAIL rand_pixel c=%0d en=%0b got=%h want=%h", c, en, out_b, exp_v);
            end
            if (de_b && int'(y_ptr_b) >= B_VA) viol++;
            if (frame_start_b) begin
                if (last_fs >= 0) begin
                    total++;
                    if (ticks - last_fs != B_FRAME) begin
                        bad++; $display("[TB] FAIL rand_frame_period got=%0d want=%0d", ticks - last_fs, B_FRAME);
                    end
                    n_period++;
                end
                last_fs = ticks;
            end
        end
        total++;
        if (viol != 0 || n_period < 1) begin
            bad++; $display("[TB] FAIL rand_de_rows got=%0d/%0d want=0/>=1", viol, n_period);
        end
    endtask

    task automatic test_quarter_rate();
        int p, last_fs_c, n_period;
        logic en;
        logic [OW-1:0] exp_v, held;
        rst_n_b = 1'b0; pix_en_b = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_b !== reset_vec(1'b0, 1'b1)) begin
            bad++; $display("[TB] FAIL quarter_reset got=%h want=%h", out_b, reset_vec(1'b0, 1'b1));
        end
        rst_n_b = 1'b1;
        p = 0; last_fs_c = -1; n_period = 0;
        held = reset_vec(1'b0, 1'b1);
        for (int c = 0; c < 8 * B_FRAME + 8; c++) begin
            en = (c % 4 == 0);
            pix_en_b = en;
            @(posedge clk); #1;
            if (en) begin
                exp_v = ref_pixel(p, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b0, 1'b1);
                p++;
            end else begin
                exp_v = {held[OW-1:2], 2'b00};
            end
            held = exp_v;
            total++;
            if (out_b !== exp_v) begin
                bad++; $display("[TB] FAIL quarter_pixel c=%0d got=%h want=%h", c, out_b, exp_v);
            end
            if (frame_start_b) begin
                if (last_fs_c >= 0) begin
                    total++;
                    if (c - last_fs_c != 4 * B_FRAME) begin
                        bad++; $display("[TB] FAIL quarter_frame_clks got=%0d want=%0d", c - last_fs_c, 4 * B_FRAME);
                    end
                    n_period++;
                end
                last_fs_c = c;
            end
        end
        total++;
        if (n_period != 2) begin
            bad++; $display("[TB] FAIL quarter_frame_count got=%0d want=2", n_period);
        end
    endtask

    task automatic test_mid_reset();
        int p;
        logic [OW-1:0] exp_v;
        rst_n_b = 1'b0; pix_en_b = 1'b1;
        @(posedge clk); #1;
        rst_n_b = 1'b1;
        // Stop while presenting (h=13, v=7): inside both sync pulses
        for (p = 0; p < 7 * 19 + 14; p++) begin
            @(posedge clk); #1;
            exp_v = ref_pixel(p, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b0, 1'b1);
            total++;
            if (out_b !== exp_v) begin
                bad++; $display("[TB] FAIL midrst_pre p=%0d got=%h want=%h", p, out_b, exp_v);
            end
        end
        total++;
        if (hsync_b !== 1'b0 || vsync_b !== 1'b1) begin
            bad++; $display("[TB] FAIL midrst_in_sync got=%b%b want=01", hsync_b, vsync_b);
        end
        rst_n_b = 1'b0; pix_en_b = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_b !== reset_vec(1'b0, 1'b1)) begin
            bad++; $display("[TB] FAIL midrst_reset got=%h want=%h", out_b, reset_vec(1'b0, 1'b1));
        end
        rst_n_b = 1'b1; pix_en_b = 1'b1;
        @(posedge clk); #1;
        total++;
        if (de_b !== 1'b1 || frame_start_b !== 1'b1 || line_start_b !== 1'b1 ||
            x_ptr_b !== '0 || y_ptr_b !== '0) begin
            bad++; $display("[TB] FAIL midrst_first got=%h want=%h", out_b,
                            ref_pixel(0, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b0, 1'b1));
        end
        // Run across the (18,10) -> (0,0) frame boundary
        for (p = 1; p < B_FRAME + 20; p++) begin
            @(posedge clk); #1;
            exp_v = ref_pixel(p, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b0, 1'b1);
            total++;
            if (out_b !== exp_v) begin
                bad++; $display("[TB] FAIL midrst_post p=%0d got=%h want=%h", p, out_b, exp_v);
            end
        end
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        pix_en_a = 1'b0; pix_en_b = 1'b0; pix_en_c = 1'b0;
        test_reset();
        test_default_lines();
        test_wide_mode();
        test_random_enable();
        test_quarter_rate();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator: the next-generation replacement for the fixed 640×480@60 VGA adapter.
- Produces registered hsync, vsync, data-enable and pixel coordinates for any mode described by four porch/sync parameters per axis.
- Supports programmable sync polarity, a pixel-clock-enable input for running off a faster system clock, and frame/line start strobes for the game renderer and frame-buffer fetch logic.
- Sits between the clock divider and the pixel-colour mux in the Flappy-VGA display path.

## Interface
Parameters:
- CW, 12: counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: hsync active level (0 = active-low).
- VS_POL, 0: vsync active level (0 = active-low).

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  reset; synchronous, active-low.
- pix_en  in  1  pixel tick; tie to 1 when clk is the pixel clock.
- hsync  out  1  horizontal sync, HS_POL level when asserted.
- vsync  out  1  vertical sync, VS_POL level when asserted.
- de  out  1  high in the visible region.
- x_ptr  out  CW  pixel column, 0..H_ACTIVE-1 when de, else 0.
- y_ptr  out  CW  pixel row, 0..V_ACTIVE-1 when de, else 0.
- line_start  out  1  one-clk pulse at the first pixel of each visible line.
- frame_start  out  1  one-clk pulse at pixel (0,0).

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Internal counters h_cnt and v_cnt both reset to 0.
- Region order per axis: active, front porch, sync, back porch.
  - h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) → hsync asserted.
  - v_cnt uses the same rule with the vertical parameters for vsync.
- On each clk edge with pix_en=1, all outputs are loaded from the decode of the current (h_cnt, v_cnt), then the counters advance:
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt increments only on that h_cnt wrap, and wraps from V_TOTAL-1 to 0 when it coincides with the h_cnt wrap.
- pix_en=0: counters, hsync, vsync, de, x_ptr and y_ptr all hold their values.
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- x_ptr = h_cnt and y_ptr = v_cnt when de; both are 0 otherwise.
- line_start is loaded with (h_cnt==0 && v_cnt<V_ACTIVE).
- frame_start is loaded with (h_cnt==0 && v_cnt==0).
- Strobes are cleared on every clk edge where pix_en=0, so each pulse lasts exactly one clk regardless of the pix_en ratio.
- All arithmetic is unsigned CW-bit with no truncation. Parameter sanity (totals fit in CW, every field ≥1) is enforced by elaboration-time checks.

## Timing
- Reset values: h_cnt=v_cnt=0, hsync=~HS_POL, vsync=~VS_POL, de=0, x_ptr=y_ptr=0, line_start=frame_start=0.
- Latency is one enabled edge: the first pix_en edge after rst_n rises presents pixel (0,0) with de=1, frame_start=1, line_start=1.
- Reset asserted mid-frame takes effect on the next clk edge regardless of pix_en. The raster restarts from (0,0); no partial sync pulse is stretched.
- In the default mode, the edge presenting h=656 asserts hsync, and the edge presenting h=752 deasserts it.
- vsync changes on the same edge as the hsync-region boundary of the line where v_cnt enters or leaves the sync region, i.e. aligned to h=0 of that line.
- No combinational paths from inputs to outputs.

## Structure
- Shared package vga_pkg holds:
  - CW default;
  - mode constant sets for 640×480@60 (above) and 800×600@60 (H 800/40/128/88, V 600/1/4/23, positive polarity);
  - H_TOTAL/V_TOTAL helper functions.
- Sub-module vga_axis_counter: a CW-bit wrap counter with enable, terminal count and wrap-out; instantiated once per axis, with the horizontal wrap-out driving the vertical enable.

## Test plan
- Default params, pix_en=1, run one frame → exactly 420000 clks between frame_start pulses; 525 hsync pulses, each 96 clks low; vsync low for 1600 clks.
- Per line → de high 640 consecutive clks, x_ptr stepping 0..639; hsync falls 16 clks after de falls.
- pix_en high one clk in four → all timings scale ×4; frame_start and line_start pulses each exactly 1 clk wide; outputs held during gaps.
- rst_n low for one clk at (h=700, v=490), inside hsync and vsync → next clk shows reset values; first enabled edge after release shows (0,0) with de=1, frame_start=1.
- Override to 800×600 mode with HS_POL=VS_POL=1 → hsync high for 128 clks starting 840 clks after line start; V_TOTAL=628 lines; x_ptr max 799.
- Boundary at (799,524) → next enabled edge shows x_ptr=0, y_ptr=0, frame_start=1; no pixel with y_ptr ≥ 480 while de=1.
